// File: rtl/mfe_pkg.sv
// Shared median-filter-engine definitions: image geometry, result memory address
// packing and the unloader state encoding.
package mfe_pkg;

    localparam int MFE_IMG_LOG2 = 7;
    localparam int MFE_IMG_DIM  = 1 << MFE_IMG_LOG2;
    localparam int MFE_ADDR_W   = 2 * MFE_IMG_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } mfe_state_t;

    // The engine writes with this same packing, so read order and layout stay in step.
    function automatic logic [MFE_ADDR_W-1:0] mfe_pack_addr(
        input logic [MFE_IMG_LOG2-1:0] x,
        input logic [MFE_IMG_LOG2-1:0] y
    );
        return {x, y};
    endfunction

endpackage

// File: rtl/mfe_sync_fifo.sv
// Small synchronous FIFO holding returned pixels plus their last tag; the head
// entry is presented combinationally.
module mfe_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 9,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mfe_result_unloader.sv
// Drains the 128x128 result memory in row-major order onto a valid/ready byte
// stream, accumulating a frame checksum and pulsing done after the last beat.
module mfe_result_unloader
    import mfe_pkg::*;
#(
    parameter int IMG_LOG2  = MFE_IMG_LOG2,
    parameter int BUF_DEPTH = 2,
    parameter int CSUM_W    = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mfe_busy,
    output logic [2*IMG_LOG2-1:0] addr,
    output logic                  ren,
    input  logic [7:0]            data_rd,
    output logic                  m_valid,
    output logic [7:0]            m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  done,
    output logic [CSUM_W-1:0]     checksum
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [IMG_LOG2-1:0] COORD_MAX = '1;

    mfe_state_t          state;
    mfe_state_t          next_state;
    logic [IMG_LOG2-1:0] x;
    logic [IMG_LOG2-1:0] y;
    logic                inflight;
    logic                inflight_last;
    logic                pop;
    logic                issue;
    logic                at_end;
    logic [8:0]          head;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      credit_used;

    assign pop      = m_valid & m_ready;
    assign m_valid  = (fifo_count != '0);
    assign m_data   = head[7:0];
    assign m_last   = m_valid & head[8];
    assign at_end   = (x == COORD_MAX) && (y == COORD_MAX);
    assign addr     = mfe_pack_addr(x, y);

    // A slot is reserved for every read still in flight, so the FIFO can never overflow.
    assign credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    assign issue       = (state == READ) && (credit_used < (CNT_W + 1)'(BUF_DEPTH));
    assign ren         = issue;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (mfe_busy)        next_state = ARMED;
            ARMED:   if (!mfe_busy)       next_state = READ;
            READ:    if (issue && at_end) next_state = DRAIN;
            DRAIN:   if (pop && m_last)   next_state = IDLE;
            default:                      next_state = IDLE;
        endcase
    end

    // Coordinates and checksum restart on busy falling; busy during READ/DRAIN is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x             <= '0;
            y             <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            checksum      <= '0;
            done          <= 1'b0;
        end else begin
            if (state == ARMED && !mfe_busy) begin
                x        <= '0;
                y        <= '0;
                checksum <= '0;
            end else begin
                if (issue) begin
                    x <= x + 1'b1;
                    if (x == COORD_MAX) begin
                        y <= y + 1'b1;
                    end
                end
                if (pop) begin
                    checksum <= checksum + CSUM_W'(m_data);
                end
            end
            inflight      <= issue;
            inflight_last <= issue & at_end;
            done          <= pop & m_last;
        end
    end

    mfe_sync_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data ({inflight_last, data_rd}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mfe_result_unloader.sv
// Scoreboard bench for mfe_result_unloader: a memory model plus an expected-beat
// queue filled per frame, checked by a free-running monitor on the falling edge.
module tb_mfe_result_unloader;

    localparam int CSUM_W = 24;
    localparam int DIM    = 128;
    localparam int NPIX   = DIM * DIM;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              mfe_busy = 1'b0;
    logic [13:0]       addr;
    logic              ren;
    logic [7:0]        data_rd;
    logic              m_valid;
    logic [7:0]        m_data;
    logic              m_last;
    logic              m_ready;
    logic              done;
    logic [CSUM_W-1:0] checksum;

    logic [7:0] mem [NPIX];
    logic [8:0] exp_q [$];
    logic [8:0] exp_beat;
    longint     exp_csum;

    int  compared = 0;
    int  mismatched = 0;
    int  cyc = 0;
    int  beats = 0;
    int  ren_count = 0;
    int  done_count = 0;
    int  first_ren_cyc = -1;
    int  first_valid_cyc = -1;
    int  first_hs_cyc = -1;
    int  last_hs_cyc = -1;
    int  rise_cyc = 0;
    bit  rand_ready = 1'b0;
    bit  ready_hold = 1'b0;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    mfe_result_unloader dut (
        .clk      (clk),
        .reset    (reset),
        .mfe_busy (mfe_busy),
        .addr     (addr),
        .ren      (ren),
        .data_rd  (data_rd),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren) data_rd <= mem[addr];
    end

    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? ($urandom_range(0, 99) < 30) : ready_hold;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Every handshake pops one expected beat; stalls must hold the presented beat.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", m_valid, 1);
                checkOutput("stall_data", m_data, prev_data);
                checkOutput("stall_last", m_last, prev_last);
            end
            if (ren) begin
                ren_count++;
                if (first_ren_cyc < 0) first_ren_cyc = cyc;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    reportFail("extra_beat");
                end else begin
                    exp_beat = exp_q.pop_front();
                    checkOutput("beat_data", m_data, exp_beat[7:0]);
                    checkOutput("beat_last", m_last, exp_beat[8]);
                end
                beats++;
                if (beats == 1) first_hs_cyc = cyc;
                if (m_last) last_hs_cyc = cyc;
            end
            if (done) begin
                done_count++;
                checkOutput("done_delay", cyc - last_hs_cyc, 1);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Load memory with a pattern and queue the row-major frame it should produce.
    task automatic applyStimulus(input int pattern);
        logic [7:0] pix;
        exp_q.delete();
        exp_csum        = 0;
        beats           = 0;
        ren_count       = 0;
        done_count      = 0;
        first_ren_cyc   = -1;
        first_valid_cyc = -1;
        first_hs_cyc    = -1;
        last_hs_cyc     = -1;
        for (int yy = 0; yy < DIM; yy++) begin
            for (int xx = 0; xx < DIM; xx++) begin
                pix = (pattern == 0) ? 8'((xx + yy) % 256) : 8'h80;
                mem[xx * DIM + yy] = pix;
                exp_q.push_back({(xx == DIM - 1) && (yy == DIM - 1), pix});
                exp_csum = exp_csum + pix;
            end
        end
        exp_csum = exp_csum % (longint'(1) << CSUM_W);
    endtask

    task automatic busyFor(input logic lvl, input int n);
        mfe_busy = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitFrameDone(input int budget);
        int n = 0;
        while (done_count == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_count == 0) reportFail("done_timeout");
        repeat (5) @(negedge clk);
    endtask

    task automatic checkFrameEnd(input string tag);
        checkOutput({tag, "_beats"}, beats, NPIX);
        checkOutput({tag, "_queue_empty"}, exp_q.size(), 0);
        checkOutput({tag, "_ren_count"}, ren_count, NPIX);
        checkOutput({tag, "_done_count"}, done_count, 1);
        checkOutput({tag, "_checksum"}, checksum, exp_csum[31:0]);
    endtask

    initial begin
        int n;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_ren", ren, 0);
        checkOutput("rst_valid", m_valid, 0);
        checkOutput("rst_data", m_data, 0);
        checkOutput("rst_last", m_last, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_checksum", checksum, 0);
        reset = 1'b1;

        $display("[TB] frame A: gradient pattern, ready held high");
        applyStimulus(0);
        ready_hold = 1'b1;
        @(posedge clk); #1;
        busyFor(1'b1, 5);
        busyFor(1'b0, 1);
        waitFrameDone(40000);
        checkFrameEnd("A");
        checkOutput("A_first_valid_latency", first_valid_cyc - first_ren_cyc, 2);
        checkOutput("A_no_gaps", last_hs_cyc - first_hs_cyc, NPIX - 1);

        $display("[TB] frame B: constant 0x80, double busy pulse, initial stall");
        applyStimulus(1);
        @(negedge clk);
        ready_hold = 1'b0;
        @(posedge clk); #1;
        busyFor(1'b1, 3);
        busyFor(1'b0, 3);
        rise_cyc = cyc;
        busyFor(1'b1, 3);
        busyFor(1'b0, 1);
        checkOutput("B_start_on_first_fall", (first_ren_cyc >= 0) && (first_ren_cyc < rise_cyc), 1);
        n = 0;
        while ((first_ren_cyc < 0 || cyc < first_ren_cyc + 20) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("B_stall_ren_count", ren_count, 2);
        checkOutput("B_stall_valid", m_valid, 1);
        checkOutput("B_stall_data", m_data, 8'h80);
        checkOutput("B_stall_last", m_last, 0);
        ready_hold = 1'b1;
        waitFrameDone(40000);
        checkFrameEnd("B");
        checkOutput("B_checksum_const", checksum, 32'h200000);
        checkOutput("B_resume_no_gaps", last_hs_cyc - first_hs_cyc, NPIX - 1);
        repeat (50) @(negedge clk);
        checkOutput("B_no_second_frame", ren_count, NPIX);

        $display("[TB] frame C: reset after 1000 beats");
        applyStimulus(0);
        @(posedge clk); #1;
        busyFor(1'b1, 5);
        busyFor(1'b0, 1);
        n = 0;
        while (beats < 1000 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (beats < 1000) reportFail("C_beat_timeout");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("C_rst_addr", addr, 0);
        checkOutput("C_rst_ren", ren, 0);
        checkOutput("C_rst_valid", m_valid, 0);
        checkOutput("C_rst_data", m_data, 0);
        checkOutput("C_rst_last", m_last, 0);
        checkOutput("C_rst_done", done, 0);
        checkOutput("C_rst_checksum", checksum, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        n = ren_count;
        repeat (20) @(negedge clk);
        checkOutput("C_no_done", done_count, 0);
        checkOutput("C_idle_after_reset", ren_count, n);
        checkOutput("C_valid_after_reset", m_valid, 0);

        $display("[TB] frame D: fresh frame with random ready");
        applyStimulus(0);
        @(negedge clk);
        rand_ready = 1'b1;
        @(posedge clk); #1;
        busyFor(1'b1, 5);
        busyFor(1'b0, 1);
        n = 0;
        while (beats < 4096 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        rand_ready = 1'b0;
        ready_hold = 1'b1;
        waitFrameDone(60000);
        checkFrameEnd("D");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mfe_result_unloader.md
Name: mfe_result_unloader

Overview:
- Drains the median filter engine's 128x128 result memory once the engine finishes a frame.
- Streams the pixels out in row-major order (y outer, x inner) over a valid/ready byte stream.
- Produces a frame checksum and a done pulse.
- Sits between the result memory read port and the host/testbench output path; it is the read-side counterpart of the engine's write path.

Parameters:
- IMG_LOG2, 7, log2 of image width/height (128x128); memory address is 2*IMG_LOG2 bits.
- BUF_DEPTH, 2, output skid FIFO entries; must be >= 2 for full throughput.
- CSUM_W, 24, checksum width; must be >= 8+2*IMG_LOG2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- mfe_busy  in  1  busy flag from the filter engine
- addr  out  14  result memory read address, {x[6:0], y[6:0]}
- ren  out  1  result memory read strobe
- data_rd  in  8  result memory read data, valid exactly 1 cycle after ren
- m_valid  out  1  output byte valid
- m_data  out  8  output pixel
- m_last  out  1  high with the final pixel (x=127, y=127)
- m_ready  in  1  downstream accept
- done  out  1  one-cycle pulse after the last beat is accepted
- checksum  out  CSUM_W  sum of all pixels accepted this frame; held until the next frame starts

Behaviour:
- Reset values: addr=0, ren=0, m_valid=0, m_data=0, m_last=0, done=0, checksum=0. FIFO is emptied, x=y=0, state=IDLE.
- IDLE: on mfe_busy=1 go to ARMED.
- ARMED: on mfe_busy=0 (the falling edge of busy) clear checksum and x/y, then go to READ. A busy that rises again before falling keeps the block in ARMED.
- READ:
  - Issue a read with ren=1, addr={x,y} in any cycle where (fifo_count + inflight - pop) < BUF_DEPTH. pop = m_valid & m_ready this cycle.
  - Coordinate advance per issued read: x increments; at x=127, x wraps to 0 and y increments.
  - After issuing (127,127), go to DRAIN. ren is never asserted outside READ.
- Read return: the cycle after ren, data_rd is pushed into the FIFO together with a last tag. The tag is set iff that read was (127,127).
- Output:
  - m_valid = FIFO non-empty; m_data and m_last come from the FIFO head.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_valid never deasserts without a handshake.
- Throughput: with m_ready held at 1, the first m_valid appears 2 cycles after entering READ. After that, 1 beat/cycle with no bubbles, for 16384 consecutive beats.
- Checksum: checksum += m_data on every handshake; zero-extended, wraps modulo 2^CSUM_W.
- DRAIN: when the beat with m_last is accepted, pulse done for 1 cycle and go to IDLE. checksum is then final.
- mfe_busy going high during READ/DRAIN is a protocol error and is ignored; the frame completes normally.
- Reset mid-frame: all state is cleared immediately and asynchronously. Any in-flight read data is discarded. No done pulse is produced.

Decomposition:
- Shared package mfe_pkg:
  - IMG_LOG2, image dimension constants
  - the address packing function {x,y}, shared with the filter engine so the read order and write layout agree
  - state encoding enum (IDLE, ARMED, READ, DRAIN)
- Sub-module mfe_sync_fifo: BUF_DEPTH x 9-bit synchronous FIFO (data + last tag) with push/pop/count. The top level holds the FSM, coordinate counters, credit logic and checksum.

Test Plan:
- Busy 1 for 5 cycles then 0; memory holds pixel(x,y) = (x+y)&0xFF; m_ready=1.
  - Required: 16384 beats in row-major order with no gaps after the first.
  - Required: m_last only on beat 16383; done one cycle after that beat.
  - Required: checksum equals the software sum.
- Constant 0x80 memory; m_ready=1. Required: checksum = 0x200000 and exactly 16384 ren pulses.
- Random m_ready at 30% duty.
  - Required: FIFO never overflows and no beat is lost or duplicated; stream matches the first scenario.
  - Required: m_data is stable across every stall cycle.
- m_ready=0 for the first 20 cycles of READ.
  - Required: ren stops after 2 reads.
  - Required: the first beat (pixel 0,0) is presented and held; flow resumes at 1 beat/cycle once ready=1.
- Assert reset at beat 1000, then deassert.
  - Required: all outputs return to 0 with no done pulse.
  - Required: the next busy 1→0 sequence produces a complete fresh frame starting at (0,0).
- Busy pulses 1→0→1→0 before READ begins. Required: unload starts only on the first falling edge; the second busy pulse during READ does not disturb the stream.
